// File: rtl/mips_pkg.sv
// Shared core definitions: memctrl command codes and the
// data-memory access unit state type.
package mips_pkg;

    localparam logic [1:0] MEMCTRL_NONE  = 2'b00;
    localparam logic [1:0] MEMCTRL_LOAD  = 2'b01;
    localparam logic [1:0] MEMCTRL_STORE = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE,
        ERR
    } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory bus: single request held until a one-cycle ack.
// The access unit is the master, the memory is the slave.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Data-memory access unit: runs one load/store bus cycle per
// memctrl command and stalls the core until it completes.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        memctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              done,
    output logic              fault,
    mem_access_unit_if.master bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mau_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             cmd_valid;
    logic             aligned;

    assign cmd_valid = (memctrl == MEMCTRL_LOAD) ||
                       (memctrl == MEMCTRL_STORE);
    assign aligned   = (addr[1:0] == 2'b00);

    // The IDLE term lets the PC freeze in the same cycle the command arrives.
    assign stall = (state == BUSY) ||
                   ((state == IDLE) && cmd_valid);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            cnt           <= '0;
            rdata         <= '0;
            done          <= 1'b0;
            fault         <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    if (cmd_valid && aligned) begin
                        state         <= BUSY;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= (memctrl == MEMCTRL_STORE);
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= wdata;
                    end else if (cmd_valid) begin
                        state <= ERR;
                        fault <= 1'b1;
                    end
                end
                BUSY: begin
                    // An ack coinciding with expiry still completes the access.
                    if (bus.mem_ack) begin
                        if (!bus.mem_we) begin
                            rdata <= bus.mem_rdata;
                        end
                        state       <= DONE;
                        done        <= 1'b1;
                        bus.mem_req <= 1'b0;
                        cnt         <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state       <= ERR;
                        fault       <= 1'b1;
                        bus.mem_req <= 1'b0;
                        cnt         <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                ERR: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
